shift_arbiter: RTL

//  Shares one combinational shifter between two requesters (0 = integer pipe, 1 = address/CSR helper).

---
 rtl/shift_arb_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/shift_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
package shift_arb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 3;

    localparam logic [OPW-1:0] F3_SLL = 3'b001;
    localparam logic [OPW-1:0] F3_SRX = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [OPW-1:0]  op;
        logic            arith;
    } sh_req_t;

    function automatic logic op_legal(logic [OPW-1:0] op);
        return (op == F3_SLL) || (op == F3_SRX);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant plus the priority pointer register.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // The requester just served loses priority to the other one.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (gnt_o != 2'b00)) begin
            ptr_d = ~gnt_o[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one combinational shifter between two requesters; one shift in flight.
// Optional SHIFT_ARB_OPCHK_EN adds resp_err_o and squashes unsupported opcodes.
module shift_arbiter
    import shift_arb_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rq0_valid_i,
    output logic            rq0_ready_o,
    input  logic [XLEN-1:0] rq0_a_i,
    input  logic [XLEN-1:0] rq0_b_i,
    input  logic [OPW-1:0]  rq0_op_i,
    input  logic            rq0_arith_i,
    input  logic            rq1_valid_i,
    output logic            rq1_ready_o,
    input  logic [XLEN-1:0] rq1_a_i,
    input  logic [XLEN-1:0] rq1_b_i,
    input  logic [OPW-1:0]  rq1_op_i,
    input  logic            rq1_arith_i,
    output logic [XLEN-1:0] sh_a_o,
    output logic [XLEN-1:0] sh_b_o,
    output logic [OPW-1:0]  sh_op_o,
    output logic            sh_arith_o,
    input  logic [XLEN-1:0] sh_r_i,
    output logic            resp_valid_o,
    output logic            resp_id_o,
    output logic [XLEN-1:0] resp_r_o,
    input  logic            resp_ready_i
`ifdef SHIFT_ARB_OPCHK_EN
    ,
    output logic            resp_err_o
`endif
);

    state_e          state_q, state_d;
    sh_req_t         sh_q, sh_d;
    logic            id_q, id_d;
    logic [XLEN-1:0] resp_r_q, resp_r_d;
    logic            resp_valid_q, resp_valid_d;
    logic            can_grant_c, take_c;
    logic [1:0]      gnt_c;
    sh_req_t         rq0_c, rq1_c, sel_c;
`ifdef SHIFT_ARB_OPCHK_EN
    logic            err_q, err_d;
    logic            resp_err_q, resp_err_d;
`endif

    assign rq0_c = '{a: rq0_a_i, b: rq0_b_i, op: rq0_op_i, arith: rq0_arith_i};
    assign rq1_c = '{a: rq1_a_i, b: rq1_b_i, op: rq1_op_i, arith: rq1_arith_i};
    assign sel_c = gnt_c[1] ? rq1_c : rq0_c;

    rr_arbiter2 u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     ({rq1_valid_i, rq0_valid_i}),
        .advance_i (take_c),
        .gnt_o     (gnt_c)
    );

    // Grants are offered only when idle or on the response handshake cycle.
    assign rq0_ready_o = can_grant_c & gnt_c[0] & ~rst_i;
    assign rq1_ready_o = can_grant_c & gnt_c[1] & ~rst_i;
    assign take_c      = can_grant_c & (gnt_c != 2'b00) & ~rst_i;

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        id_d         = id_q;
        resp_r_d     = resp_r_q;
        can_grant_c  = 1'b0;
`ifdef SHIFT_ARB_OPCHK_EN
        err_d        = err_q;
        resp_err_d   = resp_err_q;
`endif
        unique case (state_q)
            IDLE: can_grant_c = 1'b1;
            EXEC: begin
                resp_r_d = sh_r_i;
`ifdef SHIFT_ARB_OPCHK_EN
                resp_err_d = err_q;
                if (err_q) begin
                    resp_r_d = '0;
                end
`endif
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    can_grant_c = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take_c) begin
            sh_d    = sel_c;
            id_d    = gnt_c[1];
            state_d = EXEC;
`ifdef SHIFT_ARB_OPCHK_EN
            err_d = ~op_legal(sel_c.op);
            if (!op_legal(sel_c.op)) begin
                sh_d.op = '0;
            end
`endif
        end
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            sh_q         <= '0;
            id_q         <= 1'b0;
            resp_r_q     <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            id_q         <= id_d;
            resp_r_q     <= resp_r_d;
            resp_valid_q <= resp_valid_d;
        end
    end

`ifdef SHIFT_ARB_OPCHK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q      <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign resp_err_o = resp_err_q;
`endif

    assign sh_a_o       = sh_q.a;
    assign sh_b_o       = sh_q.b;
    assign sh_op_o      = sh_q.op;
    assign sh_arith_o   = sh_q.arith;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = id_q;
    assign resp_r_o     = resp_r_q;

endmodule
